// File: rtl/partial_output_checker.sv
// Masked compare of partial-circuit outputs against golden outputs over a fixed-length run; all outputs registered.
// Optional macro PARTIAL_CHK_STOP_ON_FAIL_EN ends the run at the first mismatch (FAIL state).
module partial_output_checker #(
  parameter  int WIDTH       = 2,
  parameter  int NUM_SAMPLES = 256,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             start,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] dut_O,
  input  logic [WIDTH-1:0] gold_O,
  input  logic [WIDTH-1:0] mask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_diff
);

`ifdef PARTIAL_CHK_STOP_ON_FAIL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FAIL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [WIDTH-1:0] mask_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] diff;
  logic             xfer;
  logic             hit;
  logic             last;
  logic             cnt_sat;
  logic             first_hit;

  assign xfer      = valid && ready;
  assign diff      = (dut_O ^ gold_O) & ~mask_q;
  assign hit       = |diff;
  assign last      = (idx == LAST_IDX);
  assign cnt_sat   = (mismatch_count == CNT_MAX);
  // A zero count means no mismatch has been seen yet this run (the counter never wraps).
  assign first_hit = (mismatch_count == '0);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state           <= IDLE;
      ready           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch_count  <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
      idx             <= '0;
      mask_q          <= '0;
    end else begin
      case (state)
        RUN: begin
          if (xfer) begin
            if (hit) begin
              if (first_hit) begin
                first_fail_idx  <= idx;
                first_fail_diff <= diff;
              end
              if (!cnt_sat) mismatch_count <= mismatch_count + CNT_W'(1);
            end
`ifdef PARTIAL_CHK_STOP_ON_FAIL_EN
            if (hit) begin
              state <= FAIL;
              ready <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end else
`endif
            if (last) begin
              state <= DONE;
              ready <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= first_hit && !hit;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          // IDLE, DONE and FAIL all restart identically on start.
          if (start) begin
            state           <= RUN;
            ready           <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            mismatch_count  <= '0;
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
            idx             <= '0;
            mask_q          <= mask;
          end
        end
      endcase
    end
  end

endmodule
